// File: rtl/count_display_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | count_display_pkg                                                        |
// | Shared FSM encodings, segment patterns and helpers for count_display.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package count_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  localparam int NUM_DIGITS = 5;

  // Active-low cathodes, bit order g..a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  function automatic logic [19:0] dabble_adjust(input logic [19:0] bcd);
    logic [19:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return adj;
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_display_bin2bcd16.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin2bcd16                                                                |
// | Free-running 16-bit binary to 5-digit BCD converter (18-cycle period).  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bin2bcd16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bin_in,
  output logic [19:0] bcd_out,
  output logic        valid_pulse
);
  import count_display_pkg::*;

  conv_state_t r_state;
  logic [15:0] r_bin;
  logic [19:0] r_acc;
  logic [3:0]  r_cnt;
  logic [19:0] w_adj;

  assign w_adj = dabble_adjust(r_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bin       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      bcd_out     <= '0;
      valid_pulse <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bin       <= bin_in;
          r_acc       <= '0;
          r_cnt       <= '0;
          valid_pulse <= 1'b0;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_acc <= {w_adj[18:0], r_bin[15]};
          r_bin <= {r_bin[14:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state     <= ST_LOAD;
            valid_pulse <= 1'b1;
          end
        end
        ST_LOAD: begin
          bcd_out     <= r_acc;
          valid_pulse <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          valid_pulse <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_display.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | count_display                                                            |
// | Multiplexed 5-digit seven-segment display of a 16-bit count.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module count_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] count_in,
  output logic [7:0]  an_out,
  output logic [6:0]  seg_out,
  output logic        dp_out
);
  import count_display_pkg::*;

  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_idx;
  logic [19:0]      w_bcd;
  logic             w_unused_valid;
  logic [19:0]      w_upper;
  logic             w_blank;

  bin2bcd16 u_conv (
    .clk         (clk),
    .rst         (rst),
    .bin_in      (count_in),
    .bcd_out     (w_bcd),
    .valid_pulse (w_unused_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Shifting the selected nibble down to the bottom also leaves all higher
  // nibbles above it, so a zero result means "this digit is a leading zero".
  assign w_upper = w_bcd >> {r_idx, 2'b00};
  assign w_blank = (r_idx != 3'd0) && (w_upper == 20'd0);

  assign seg_out = w_blank ? SEG_BLANK : seg_decode(w_upper[3:0]);
  assign an_out  = ~(8'd1 << r_idx);
  assign dp_out  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_count_display.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_count_display                                                         |
// | Directed self-checking bench for count_display with SCAN_DIV=4.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_count_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] count_in = 16'd0;
  logic [7:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [19:0] prev_bcd = 20'd0;

  count_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .an_out   (an_out),
    .seg_out  (seg_out),
    .dp_out   (dp_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_an(input int c);
    return ~(8'd1 << ((c / 4) % 5));
  endfunction

  // segs packs digit i expected pattern at [7*i +: 7]
  task automatic scan(input logic [34:0] segs, input int n);
    for (int i = 0; i < n; i++) begin
      int d;
      d = (cyc / 4) % 5;
      chk("an_scan", an_out, exp_an(cyc));
      chk("seg_scan", seg_out, segs[7*d +: 7]);
      chk("dp", dp_out, 1);
      tick();
    end
  endtask

  task automatic conv(input logic [15:0] v, input logic [19:0] e);
    int k;
    count_in = v;
    k = ((cyc + 17) / 18) * 18;
    wait_to(k + 17);
    chk("bcd_hold", dut.u_conv.bcd_out, prev_bcd);
    tick();
    chk("bcd_load", dut.u_conv.bcd_out, e);
    prev_bcd = e;
  endtask

  initial begin
    int k;
    // Reset for two edges with count_in = 0
    rst = 1'b1;
    count_in = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", an_out, 8'b11111110);
    chk("rst_seg", seg_out, S0);
    chk("rst_dp", dp_out, 1);
    chk("rst_bcd", dut.u_conv.bcd_out, 20'h0);
    chk("rst_state", dut.u_conv.r_state, 2'd0);
    rst = 1'b0;
    cyc = 0;

    scan({SB, SB, SB, SB, S0}, 20);

    conv(16'd12345, 20'h12345);
    scan({S1, S2, S3, S4, S5}, 20);

    conv(16'd65535, 20'h65535);
    scan({S6, S5, S5, S3, S5}, 20);

    conv(16'd7, 20'h00007);
    scan({SB, SB, SB, SB, S7}, 20);

    conv(16'd100, 20'h00100);
    scan({SB, SB, S1, S0, S0}, 20);

    // Input changes on the 5th SHIFT cycle must not disturb the conversion
    count_in = 16'd42;
    k = ((cyc + 17) / 18) * 18;
    wait_to(k + 5);
    chk("mid_state_shift", dut.u_conv.r_state, 2'd1);
    count_in = 16'd9999;
    wait_to(k + 17);
    chk("chg_hold", dut.u_conv.bcd_out, prev_bcd);
    wait_to(k + 18);
    chk("chg_first", dut.u_conv.bcd_out, 20'h00042);
    wait_to(k + 35);
    chk("chg_first_held", dut.u_conv.bcd_out, 20'h00042);
    wait_to(k + 36);
    chk("chg_second", dut.u_conv.bcd_out, 20'h09999);

    // Reset in the middle of SHIFT
    k = ((cyc + 17) / 18) * 18;
    wait_to(k + 7);
    chk("pre_rst_state", dut.u_conv.r_state, 2'd1);
    rst = 1'b1;
    tick();
    chk("mrst_bcd", dut.u_conv.bcd_out, 20'h0);
    chk("mrst_state", dut.u_conv.r_state, 2'd0);
    chk("mrst_an", an_out, 8'b11111110);
    chk("mrst_seg", seg_out, S0);
    rst = 1'b0;
    cyc = 0;

    // 40 cycles of scanning while a fresh conversion of 9999 completes
    for (int i = 0; i < 40; i++) begin
      chk("an_seq", an_out, exp_an(cyc));
      chk("dp_seq", dp_out, 1);
      if (cyc == 17) chk("post_rst_hold", dut.u_conv.bcd_out, 20'h0);
      if (cyc == 18) chk("post_rst_load", dut.u_conv.bcd_out, 20'h09999);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
